m_dm: RTL
=========

# m_dm

Data memory for the M stage of the five-stage pipeline. Performs word, halfword and byte loads and stores against an internal word array. Produces the sign- or zero-extended load value that the MEM/WB register captures as its read-data input on the same clock edge. Also reports misaligned or out-of-range accesses through a sticky error flag.

## Interface
Parameters:
- `DEPTH`, 3072: number of 32-bit words in the array.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be word-aligned.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `MemWrite` input 1: store request this cycle.
- `Op` input 3: access type:
  - 000 word.
  - 001 byte signed.
  - 010 byte unsigned.
  - 011 half signed.
  - 100 half unsigned.
  - 101–111 treated as word.
  - For stores only the width matters.
- `A` input 32: byte address from the M-stage ALU result.
- `WD` input 32: store data; the low byte or halfword is used for narrow stores.
- `PC` input 32: PC of the M-stage instruction; used for error capture only.
- `RD` output 32: extended load result; combinational.
- `Err` output 1: sticky access-error flag.
- `ErrPC` output 32: PC of the first erroneous access.

## Operation
- Word index = (`A` − `BASE_ADDR`) >> 2. In range iff the offset is below `DEPTH`*4.
- Little-endian byte lanes:
  - `A[1:0]`=0 selects bits 7:0, through 3 selecting bits 31:24.
  - Half at `A[1]`=0 selects bits 15:0; `A[1]`=1 selects bits 31:16.
- Load path (combinational from `A`, `Op` and current array contents):
  - Word: the full word.
  - Byte/half: the selected lane, sign-extended for signed `Op`, zero-extended for unsigned `Op`.
  - Out-of-range address: `RD` = 0.
- Store path (rising edge, when `MemWrite`=1, `reset`=0, address in range and access legal): only the selected byte lanes are updated; other lanes keep their value.
- Out-of-range stores are dropped and never wrap.
- Alignment handling is set by the macro below.
- Error capture:
  - An error is an illegal access while `MemWrite`=1 or `Op` is a load.
  - `Op` is always decoded; the M-stage controller drives `Op`=000 and `A`=`BASE_ADDR` for non-memory instructions.
  - On the first error, `Err` is set to 1 on the next edge and `ErrPC` is set to `PC`.
  - Later errors do not overwrite `ErrPC`.

## Timing
- `RD` has zero latency and is valid in the same cycle as `A`/`Op`.
- A load and a store to the same word in the same cycle: `RD` returns the pre-store contents. The store is visible from the next cycle.
- Store latency is 1 edge.
- Reset:
  - On an edge with `reset`=1, every array word is cleared to 0, `Err` is set to 0 and `ErrPC` is set to 0.
  - A concurrent store is discarded.
  - After reset, `RD` reads 0 at every address.
- Reset asserted mid-sequence takes priority over any pending store or error capture on that edge.
- Out-of-range plus misaligned on the same access counts as one error and causes one `ErrPC` capture.

## Configuration
- `DM_ALIGN_CHECK_EN` defined:
  - Word access with `A[1:0]`≠0, or half access with `A[0]`=1, is illegal.
  - An illegal store is suppressed.
  - An illegal load returns `RD`=0.
  - Either case raises the error.
  - Out-of-range also raises the error.
- `DM_ALIGN_CHECK_EN` undefined:
  - The low address bits are forced to natural alignment: word ignores `A[1:0]`, half ignores `A[0]`.
  - Out-of-range accesses are dropped or read 0 but do not raise the error.
  - `Err`=0 and `ErrPC`=0 permanently.
  - The ports remain present.

## Test plan
- Reset, then store word `WD`=32'h1234_5678 at `A`=0 → next cycle:
  - Word load at 0 gives `RD`=32'h1234_5678.
  - Unsigned byte at 3 gives 32'h0000_0012.
  - Signed byte at 0 gives 32'h0000_0078.
- Store byte 32'h0000_0080 at `A`=1 → word reads 32'h1234_8078; signed byte at 1 gives 32'hFFFF_FF80; unsigned byte gives 32'h0000_0080.
- Store half 32'h0000_BEEF at `A`=2 → word reads 32'hBEEF_8078; signed half at 2 gives 32'hFFFF_BEEF; unsigned half gives 32'h0000_BEEF.
- Same-cycle store of 32'hAAAA_AAAA and word load at `A`=0x10 → `RD`=0 that cycle and 32'hAAAA_AAAA the next.
- With the macro, word store at `A`=6, `PC`=32'h0000_3010 → word 1 unchanged; `Err`=1 and `ErrPC`=32'h0000_3010 on the next edge. A second error at a different `PC` leaves `ErrPC` unchanged.
  - Without the macro, the same access writes word 1.
- Store at `A`=`DEPTH`*4 → no word changes and a load there gives `RD`=0.
  - Store of 32'hFFFF_FFFF at 0 with `reset`=1 on the same edge → word 0 reads 0 and `Err`=0.

Source files
------------

// File: rtl/m_dm_if.sv
// M-stage data-memory port bundle: request signals from the pipeline,
// combinational load data and sticky error status back from the memory.
interface m_dm_if;
    logic        MemWrite;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] PC;
    logic [31:0] RD;
    logic        Err;
    logic [31:0] ErrPC;

    modport master (
        output MemWrite, Op, A, WD, PC,
        input  RD, Err, ErrPC
    );

    modport slave (
        input  MemWrite, Op, A, WD, PC,
        output RD, Err, ErrPC
    );
endinterface

// File: rtl/m_dm.sv
// M-stage data memory: byte/half/word loads and stores with sticky error capture.
// Optional feature macro: DM_ALIGN_CHECK_EN (misalignment is an error instead of being masked).
module m_dm #(
    parameter int          DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic   clk,
    input logic   reset,
    m_dm_if.slave bus
);
    localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    logic [31:0]   mem_q [DEPTH];
    logic          err_q, err_d;
    logic [31:0]   errpc_q, errpc_d;

    logic [31:0]   off;
    logic          in_range;
    logic [IW-1:0] idx;
    logic          is_byte, is_half, is_word, sgn;
    logic [1:0]    lane;
    logic          illegal;
    logic          err_now;
    logic [31:0]   word_rd;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   rd;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
    logic          we;
`ifdef DM_ALIGN_CHECK_EN
    logic          misaligned;
`endif

    always_comb begin
        off      = bus.A - BASE_ADDR;
        in_range = {1'b0, off} < SPAN;
        idx      = off[IW+1:2];
        is_byte  = (bus.Op == 3'b001) || (bus.Op == 3'b010);
        is_half  = (bus.Op == 3'b011) || (bus.Op == 3'b100);
        is_word  = !is_byte && !is_half;
        sgn      = (bus.Op == 3'b001) || (bus.Op == 3'b011);
`ifdef DM_ALIGN_CHECK_EN
        lane       = off[1:0];
        misaligned = (is_word && (off[1:0] != 2'b00)) || (is_half && off[0]);
        illegal    = misaligned || !in_range;
        err_now    = illegal;
`else
        // Without checking, low address bits are masked to natural alignment.
        lane    = is_word ? 2'b00 : (is_half ? {off[1], 1'b0} : off[1:0]);
        illegal = !in_range;
        err_now = 1'b0;
`endif
    end

    // Load path reads the pre-edge array, so a same-cycle store is not forwarded.
    always_comb begin
        word_rd = in_range ? mem_q[idx] : 32'h0;
        byte_v  = word_rd[8*lane +: 8];
        half_v  = lane[1] ? word_rd[31:16] : word_rd[15:0];
        rd      = 32'h0;
        if (!illegal) begin
            if (is_byte)      rd = {{24{sgn & byte_v[7]}}, byte_v};
            else if (is_half) rd = {{16{sgn & half_v[15]}}, half_v};
            else              rd = word_rd;
        end
    end

    assign bus.RD = rd;

    always_comb begin
        wmask = 4'b1111;
        wdata = bus.WD;
        if (is_byte) begin
            wmask = 4'b0001 << lane;
            wdata = {4{bus.WD[7:0]}};
        end else if (is_half) begin
            wmask = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{bus.WD[15:0]}};
        end
        we = bus.MemWrite && !illegal && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (wmask[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Only the first error is captured; later ones leave ErrPC alone.
    always_comb begin
        err_d   = err_q;
        errpc_d = errpc_q;
        if (err_now && !err_q) begin
            err_d   = 1'b1;
            errpc_d = bus.PC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q   <= 1'b0;
            errpc_q <= 32'h0;
        end else begin
            err_q   <= err_d;
            errpc_q <= errpc_d;
        end
    end

    assign bus.Err   = err_q;
    assign bus.ErrPC = errpc_q;
endmodule
